// File: rtl/la_capture_ctrl.sv
// Logic-analyser trigger/capture controller: streams probe samples into a circular
// sample RAM through pre-trigger fill, masked level/edge trigger search and post-trigger capture.
module la_capture_ctrl #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              sample_en,
    input  logic [WIDTH-1:0]  din,
    input  logic              arm,
    input  logic              abort,
    input  logic [WIDTH-1:0]  trig_mask,
    input  logic [WIDTH-1:0]  trig_value,
    input  logic [WIDTH-1:0]  trig_edge,
    input  logic [ADDR_W-1:0] pre_count,
    input  logic [ADDR_W-1:0] post_count,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_arm_ok;
    logic                w_take;

    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W:0]     w_cnt_inc;
    logic [WIDTH-1:0]    r_prev;
    logic                r_prev_valid;

    logic [WIDTH-1:0]    r_mask;
    logic [WIDTH-1:0]    r_value;
    logic [WIDTH-1:0]    r_edge;
    logic [ADDR_W-1:0]   r_pre;
    logic [ADDR_W-1:0]   r_post;

    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [WIDTH-1:0]    r_wr_data;
    logic [ADDR_W-1:0]   r_trig_addr;
    logic                r_busy;
    logic                r_triggered;
    logic                r_done;

    logic [WIDTH-1:0]    w_lvl_ok;
    logic [WIDTH-1:0]    w_edge_ok;
    logic [WIDTH-1:0]    w_bit_ok;
    logic                w_match;

    // Count compare is one bit wider so a full-range pre/post count cannot alias.
    assign w_cnt_inc = {1'b0, r_cnt} + {{ADDR_W{1'b0}}, 1'b1};

    // Edge bits need the previous sample at the inverted level and the current at the target level.
    assign w_lvl_ok  = ~(din ^ r_value);
    assign w_edge_ok = {WIDTH{r_prev_valid}} & (r_prev ^ r_value) & w_lvl_ok;
    assign w_bit_ok  = ~r_mask | (~r_edge & w_lvl_ok) | (r_edge & w_edge_ok);
    assign w_match   = &w_bit_ok;

    always_comb begin
        w_state_nxt = r_state;
        w_arm_ok    = 1'b0;
        w_take      = 1'b0;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else if (arm && (r_state == S_IDLE || r_state == S_DONE)) begin
            w_arm_ok    = 1'b1;
            w_state_nxt = (pre_count == '0) ? S_WAIT : S_FILL;
        end else if (sample_en) begin
            case (r_state)
                S_FILL: begin
                    w_take = 1'b1;
                    if (w_cnt_inc == {1'b0, r_pre}) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    w_take = 1'b1;
                    if (w_match) begin
                        w_state_nxt = (r_post == '0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    w_take = 1'b1;
                    if (w_cnt_inc == {1'b0, r_post}) begin
                        w_state_nxt = S_DONE;
                    end
                end
                default: begin
                    w_take = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_mask       <= '0;
            r_value      <= '0;
            r_edge       <= '0;
            r_pre        <= '0;
            r_post       <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_trig_addr  <= '0;
            r_busy       <= 1'b0;
            r_triggered  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_FILL) || (w_state_nxt == S_WAIT) ||
                       (w_state_nxt == S_POST);
            r_done  <= (w_state_nxt == S_DONE);
            r_wr_en <= w_take;

            if (abort) begin
                r_triggered <= 1'b0;
            end

            if (w_arm_ok) begin
                r_mask       <= trig_mask;
                r_value      <= trig_value;
                r_edge       <= trig_edge;
                r_pre        <= pre_count;
                r_post       <= post_count;
                r_ptr        <= '0;
                r_cnt        <= '0;
                r_triggered  <= 1'b0;
                r_prev_valid <= 1'b0;
            end

            if (w_take) begin
                r_wr_addr    <= r_ptr;
                r_wr_data    <= din;
                r_ptr        <= r_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
                r_prev       <= din;
                r_prev_valid <= 1'b1;
                // Phase counters restart whenever this sample moves the FSM on.
                r_cnt        <= (w_state_nxt != r_state) ? '0 : w_cnt_inc[ADDR_W-1:0];
                if (r_state == S_WAIT && w_match) begin
                    r_trig_addr <= r_ptr;
                    r_triggered <= 1'b1;
                end
            end
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign trig_addr = r_trig_addr;
    assign busy      = r_busy;
    assign triggered = r_triggered;
    assign done      = r_done;
    assign state     = r_state;

endmodule

// File: doc/la_capture_ctrl.md
# la_capture_ctrl

Trigger and capture controller, placed directly downstream of the input sample register. On each sample strobe it takes the registered probe word and writes it into a circular sample RAM. It first fills a programmable pre-trigger window, then evaluates a masked level/edge trigger against the word, and finally records a programmable number of post-trigger samples before stopping. The RAM and the readout path belong to other blocks. This block only generates the write stream and the capture status.

## Interface
- WIDTH, 8, probe word width; matches the sample register width
- ADDR_W, 10, sample RAM address width; depth = 2^ADDR_W

- clk  in  1  system clock; all state changes on rising edge
- nreset  in  1  asynchronous, active-low reset
- sample_en  in  1  one-cycle strobe: din holds a new valid sample this cycle
- din  in  WIDTH  registered probe word from the sample register
- arm  in  1  start-capture pulse
- abort  in  1  cancel capture, return to idle
- trig_mask  in  WIDTH  1 = bit takes part in the trigger
- trig_value  in  WIDTH  required bit level; for edge bits, the level after the edge
- trig_edge  in  WIDTH  1 = bit requires an edge, 0 = bit requires a level
- pre_count  in  ADDR_W  samples to record before the trigger can fire
- post_count  in  ADDR_W  samples to record after the trigger sample
- wr_en  out  1  RAM write strobe
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  WIDTH  RAM write data
- trig_addr  out  ADDR_W  address of the trigger sample
- busy  out  1  state is FILL, WAIT or POST
- triggered  out  1  trigger has fired in the current capture
- done  out  1  capture complete; level signal
- state  out  3  IDLE=0, FILL=1, WAIT=2, POST=3, DONE=4

## Operation
- Reset:
  - All outputs are 0 and state is IDLE.
  - Internal address, counters and the previous-sample register are 0.
- Arm:
  - arm is accepted only in IDLE or DONE; it is ignored in other states.
  - On acceptance, trig_mask, trig_value, trig_edge, pre_count and post_count are latched.
  - The write pointer is set to 0; triggered, done and prev_valid are cleared.
  - The next state is FILL, or WAIT if pre_count = 0.
- Sample handling: the sample is processed when sample_en = 1 and state is FILL, WAIT or POST.
  - din is written at the current pointer.
  - The pointer increments modulo 2^ADDR_W and wraps silently.
  - prev is loaded with din, and prev_valid is set to 1.
- sample_en in IDLE or DONE, or in the same cycle as an accepted arm, is ignored.
- FILL: counts written samples. The transition to WAIT happens with the sample that makes the count equal pre_count. The trigger is not evaluated in FILL.
- WAIT: every sample is written and also evaluated. The trigger matches when, for every bit i with trig_mask[i] = 1, the following holds:
  - trig_edge[i] = 0: din[i] == trig_value[i].
  - trig_edge[i] = 1: prev_valid = 1, prev[i] == ~trig_value[i] and din[i] == trig_value[i]. A rising edge is trig_value = 1; a falling edge is trig_value = 0.
- Match behaviour:
  - trig_mask = 0 matches on the first WAIT sample.
  - Edge bits cannot match on the first sample after arm.
  - The trigger sample is itself written; its address goes to trig_addr and triggered is set.
  - The next state is POST, or DONE if post_count = 0.
- POST: counts samples after the trigger sample. The transition to DONE happens with the sample that makes the count equal post_count.
- DONE: done = 1 and busy = 0. The state holds until arm or abort.
- abort:
  - From any state, the next state is IDLE; done and triggered are cleared.
  - A sample arriving in the abort cycle is not written.
  - abort has priority over arm in the same cycle.
- Capacity: pre_count + post_count + 1 ≤ 2^ADDR_W is the caller's responsibility and is not checked. Overflow overwrites the oldest samples.

## Timing
- All outputs are registered.
- Write latency:
  - A sample accepted at cycle n gives wr_en = 1, wr_data = din(n) and wr_addr = pointer(n) at cycle n+1.
  - wr_en is a single cycle per sample and 0 otherwise.
- Trigger latency: a match at cycle n shows triggered = 1 and trig_addr valid at n+1, in the same cycle as the wr_en for the trigger sample.
- A state change takes effect at the edge after the causing cycle, so state/busy/done are visible at n+1.
- Final sample: the last post-trigger sample accepted at n gives wr_en = 1 and done = 1 together at n+1.
- Back-to-back sample_en on every cycle is supported at full rate.
- nreset assertion mid-capture forces all outputs to 0 immediately, independent of clk. After release, the block waits in IDLE for arm.

## Test plan
- Basic capture:
  - Stimulus: WIDTH=8, pre_count=4, post_count=3, trig_mask=0xFF, trig_value=0x5A, trig_edge=0. Feed samples 0x00..0x09, then 0x5A, then 0x10..0x13.
  - Required: 0x00..0x03 written during FILL; 0x5A written with trig_addr = 10; exactly 3 post samples (0x10..0x12); done = 1 together with the last wr_en; total of 14 writes.
- Rising edge on bit 0:
  - Stimulus: mask=0x01, value=0x01, edge=0x01, pre_count=0. First sample = 0x01, then 0x00, 0x01.
  - Required: no trigger on the first sample (prev invalid); trigger on the third sample, trig_addr = 2.
- Wrap-around:
  - Stimulus: ADDR_W=4, pre_count=2, trigger held off for 20 samples.
  - Required: wr_addr runs 0..15, 0..3; trig_addr = 4 for sample index 20.
- Abort:
  - Stimulus: abort asserted during POST; a second test asserts arm and abort in the same cycle in DONE.
  - Required: state = IDLE next cycle, no further wr_en, done = 0; in the combined case abort wins and state = IDLE.
- Zero counts / mask:
  - Stimulus: pre_count=0, post_count=0, trig_mask=0.
  - Required: first sample is written at address 0 as the trigger; triggered = 1 and done = 1 one cycle later.
- Asynchronous reset:
  - Stimulus: nreset pulled low between clock edges while in POST.
  - Required: all outputs read 0 before the next edge; state = IDLE; arm afterwards starts a fresh capture at address 0.
